decode_buffer: RTL

Parametrised decode stage that replaces the bare combinational decoder with a decode-on-enqueue instruction buffer between fetch and execute. Each accepted instruction is decoded into a `contral_t` bundle, checked for legality, and stored with its PC in a DEPTH-entry FIFO. Entries leave the buffer through a valid/ready handshake. RV64 word-ops and M-extension support are selectable at elaboration time.

---
 rtl/decode_buffer.sv | 367 ++++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/decode_buffer.sv
// -----------------------------------------------------------------------------
// decode_buffer
//
// Decode-on-enqueue instruction buffer sitting between fetch and execute.
// Every accepted instruction is decoded into a contral_t bundle and checked
// for legality. The result is stored next to the raw word and its PC in a
// DEPTH-entry circular FIFO. The head entry is presented to execute through a
// valid/ready handshake.
//
// Parameters
//   DEPTH  : number of FIFO entries (>= 2, any integer)
//   EN_MUL : 1 = decode MUL/DIV/DIVU/REM/REMU, 0 = treat them as illegal
//   EN_W   : 1 = decode the RV64 word opcodes, 0 = treat them as illegal
//
// Ports
//   clk         : rising-edge clock
//   reset       : asynchronous active-high reset of all control state
//   flush       : synchronous discard of every entry
//   in_valid    : fetch offers in_instr/in_pc
//   in_ready    : buffer has room for one more instruction
//   in_instr    : raw 32-bit instruction
//   in_pc       : 64-bit instruction PC
//   out_valid   : head entry is valid
//   out_ready   : execute consumes the head entry
//   out_ctl     : decoded op/alufunc/regwrite of the head entry
//   out_illegal : head entry is an illegal encoding
//   out_instr   : raw instruction of the head entry
//   out_pc      : PC of the head entry
//   count       : current occupancy
// -----------------------------------------------------------------------------

package decode_buffer_pkg;

    // Major opcodes (instr[6:0])
    localparam logic [6:0] F7_ALUI   = 7'b0010011;
    localparam logic [6:0] F7_ALU    = 7'b0110011;
    localparam logic [6:0] F7_ALUIW  = 7'b0011011;
    localparam logic [6:0] F7_ALUW   = 7'b0111011;
    localparam logic [6:0] F7_LUI    = 7'b0110111;
    localparam logic [6:0] F7_AUIPC  = 7'b0010111;
    localparam logic [6:0] F7_JAL    = 7'b1101111;
    localparam logic [6:0] F7_JALR   = 7'b1100111;
    localparam logic [6:0] F7_BRANCH = 7'b1100011;
    localparam logic [6:0] F7_LD     = 7'b0000011;
    localparam logic [6:0] F7_SD     = 7'b0100011;

    // funct7 values of the register-register groups
    localparam logic [6:0] F7_FIRST_ADD = 7'b0000000;
    localparam logic [6:0] F7_FIRST_SUB = 7'b0100000;
    localparam logic [6:0] F7_FIRST_MUL = 7'b0000001;

    // funct3 values
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    typedef logic [4:0] op_t;

    localparam op_t OP_ALUI  = 5'd0;
    localparam op_t OP_ALU   = 5'd1;
    localparam op_t OP_ALUIW = 5'd2;
    localparam op_t OP_ALUW  = 5'd3;
    localparam op_t OP_LUI   = 5'd4;
    localparam op_t OP_AUIPC = 5'd5;
    localparam op_t OP_JAL   = 5'd6;
    localparam op_t OP_JALR  = 5'd7;
    localparam op_t OP_BEQ   = 5'd8;
    localparam op_t OP_BNE   = 5'd9;
    localparam op_t OP_BLT   = 5'd10;
    localparam op_t OP_BGE   = 5'd11;
    localparam op_t OP_BLTU  = 5'd12;
    localparam op_t OP_BGEU  = 5'd13;
    localparam op_t OP_LD    = 5'd14;
    localparam op_t OP_SD    = 5'd15;

    typedef logic [3:0] alufunc_t;

    localparam alufunc_t ALU_ADD     = 4'd0;
    localparam alufunc_t ALU_SUB     = 4'd1;
    localparam alufunc_t ALU_AND     = 4'd2;
    localparam alufunc_t ALU_OR      = 4'd3;
    localparam alufunc_t ALU_XOR     = 4'd4;
    localparam alufunc_t ALU_SLL     = 4'd5;
    localparam alufunc_t ALU_SRL     = 4'd6;
    localparam alufunc_t ALU_SRA     = 4'd7;
    localparam alufunc_t ALU_COMPARE = 4'd8;
    localparam alufunc_t ALU_SMALL   = 4'd9;
    localparam alufunc_t ALU_SMALLU  = 4'd10;
    localparam alufunc_t ALU_MULT    = 4'd11;
    localparam alufunc_t ALU_DIV     = 4'd12;
    localparam alufunc_t ALU_DIVU    = 4'd13;
    localparam alufunc_t ALU_REM     = 4'd14;
    localparam alufunc_t ALU_REMU    = 4'd15;

    // All-zero value doubles as the "illegal / empty" bundle:
    // op = ALUI, alufunc = ALU_ADD, regwrite = 0.
    typedef struct packed {
        op_t      op;
        alufunc_t alufunc;
        logic     regwrite;
    } contral_t;

endpackage

module decode_buffer
    import decode_buffer_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int EN_MUL = 1,
    parameter int EN_W   = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_instr,
    input  logic [63:0]                in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output contral_t                   out_ctl,
    output logic                       out_illegal,
    output logic [31:0]                out_instr,
    output logic [63:0]                out_pc,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    localparam logic MUL_ON = (EN_MUL != 0);
    localparam logic W_ON   = (EN_W != 0);

    // ------------------------------------------------------------------
    // Decode helpers
    // ------------------------------------------------------------------

    // Shared funct3 mapping of the ALU groups. alt selects SUB over ADD
    // and SRA over SRL; callers only raise it where the encoding allows.
    function automatic alufunc_t base_func(input logic [2:0] f3, input logic alt);
        alufunc_t f;
        case (f3)
            F3_ADD:  f = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  f = ALU_SLL;
            F3_SLT:  f = ALU_SMALL;
            F3_SLTU: f = ALU_SMALLU;
            F3_XOR:  f = ALU_XOR;
            F3_SR:   f = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   f = ALU_OR;
            F3_AND:  f = ALU_AND;
            default: f = ALU_ADD;
        endcase
        return f;
    endfunction

    // M-extension funct3 mapping; the upper-half multiplies are not
    // supported, so 001/010/011 have no function of their own.
    function automatic alufunc_t mul_func(input logic [2:0] f3);
        alufunc_t f;
        case (f3)
            3'b000:  f = ALU_MULT;
            3'b100:  f = ALU_DIV;
            3'b101:  f = ALU_DIVU;
            3'b110:  f = ALU_REM;
            3'b111:  f = ALU_REMU;
            default: f = ALU_ADD;
        endcase
        return f;
    endfunction

    function automatic logic mul_legal(input logic [2:0] f3);
        return MUL_ON && (f3 != F3_SLT) && (f3 != F3_SLTU) && (f3 != F3_SLL);
    endfunction

    // ------------------------------------------------------------------
    // Combinational decode of the incoming word
    // ------------------------------------------------------------------
    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic       alt;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];
    assign alt    = in_instr[30];

    contral_t dec_ctl;
    logic     dec_legal;

    always_comb begin
        dec_ctl          = '0;
        dec_ctl.regwrite = 1'b1;
        dec_legal        = 1'b0;
        case (opcode)
            F7_ALUI: begin
                dec_legal       = 1'b1;
                dec_ctl.op      = OP_ALUI;
                // bit 30 of an immediate only means "arithmetic" for SRAI
                dec_ctl.alufunc = base_func(funct3, (funct3 == F3_SR) && alt);
            end
            F7_ALU: begin
                dec_ctl.op = OP_ALU;
                case (funct7)
                    F7_FIRST_ADD: begin
                        dec_legal       = 1'b1;
                        dec_ctl.alufunc = base_func(funct3, 1'b0);
                    end
                    F7_FIRST_SUB: begin
                        dec_legal       = (funct3 == F3_ADD) || (funct3 == F3_SR);
                        dec_ctl.alufunc = base_func(funct3, 1'b1);
                    end
                    F7_FIRST_MUL: begin
                        dec_legal       = mul_legal(funct3);
                        dec_ctl.alufunc = mul_func(funct3);
                    end
                    default: dec_legal = 1'b0;
                endcase
            end
            F7_ALUIW: begin
                dec_ctl.op      = OP_ALUIW;
                dec_legal       = W_ON && ((funct3 == F3_ADD) || (funct3 == F3_SLL) ||
                                           (funct3 == F3_SR));
                dec_ctl.alufunc = base_func(funct3, (funct3 == F3_SR) && alt);
            end
            F7_ALUW: begin
                dec_ctl.op = OP_ALUW;
                case (funct7)
                    F7_FIRST_ADD: begin
                        dec_legal       = W_ON && ((funct3 == F3_ADD) || (funct3 == F3_SLL) ||
                                                   (funct3 == F3_SR));
                        dec_ctl.alufunc = base_func(funct3, 1'b0);
                    end
                    F7_FIRST_SUB: begin
                        dec_legal       = W_ON && ((funct3 == F3_ADD) || (funct3 == F3_SR));
                        dec_ctl.alufunc = base_func(funct3, 1'b1);
                    end
                    F7_FIRST_MUL: begin
                        // DIVW/REMW/REMUW reuse the XOR/OR/AND funct3 slots
                        dec_legal       = W_ON && mul_legal(funct3);
                        dec_ctl.alufunc = mul_func(funct3);
                    end
                    default: dec_legal = 1'b0;
                endcase
            end
            F7_LUI: begin
                dec_legal  = 1'b1;
                dec_ctl.op = OP_LUI;
            end
            F7_AUIPC: begin
                dec_legal  = 1'b1;
                dec_ctl.op = OP_AUIPC;
            end
            F7_JAL: begin
                dec_legal  = 1'b1;
                dec_ctl.op = OP_JAL;
            end
            F7_JALR: begin
                dec_legal  = 1'b1;
                dec_ctl.op = OP_JALR;
            end
            F7_LD: begin
                dec_legal  = 1'b1;
                dec_ctl.op = OP_LD;
            end
            F7_SD: begin
                dec_legal        = 1'b1;
                dec_ctl.op       = OP_SD;
                dec_ctl.regwrite = 1'b0;
            end
            F7_BRANCH: begin
                dec_legal        = 1'b1;
                dec_ctl.regwrite = 1'b0;
                case (funct3)
                    3'b000: begin dec_ctl.op = OP_BEQ;  dec_ctl.alufunc = ALU_COMPARE; end
                    3'b001: begin dec_ctl.op = OP_BNE;  dec_ctl.alufunc = ALU_COMPARE; end
                    3'b100: begin dec_ctl.op = OP_BLT;  dec_ctl.alufunc = ALU_SMALL;   end
                    3'b101: begin dec_ctl.op = OP_BGE;  dec_ctl.alufunc = ALU_SMALL;   end
                    3'b110: begin dec_ctl.op = OP_BLTU; dec_ctl.alufunc = ALU_SMALLU;  end
                    3'b111: begin dec_ctl.op = OP_BGEU; dec_ctl.alufunc = ALU_SMALLU;  end
                    default: dec_legal = 1'b0;
                endcase
            end
            default: dec_legal = 1'b0;
        endcase

        // Illegal words are stored as a harmless non-writing ALUI/ADD.
        if (!dec_legal) begin
            dec_ctl = '0;
        end
    end

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             push;
    logic             pop;

    assign in_ready  = (count != CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Explicit wrap so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            // flush wins over any push/pop in the same cycle
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= ptr_next(tail);
            end
            if (pop) begin
                head <= ptr_next(head);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Entry storage (data only, never reset)
    // ------------------------------------------------------------------
    contral_t    ctl_mem   [DEPTH];
    logic        ill_mem   [DEPTH];
    logic [31:0] instr_mem [DEPTH];
    logic [63:0] pc_mem    [DEPTH];

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            ctl_mem[tail]   <= dec_ctl;
            ill_mem[tail]   <= !dec_legal;
            instr_mem[tail] <= in_instr;
            pc_mem[tail]    <= in_pc;
        end
    end

    // Head entry read-out. Gating with out_valid makes the outputs read as
    // zero when empty (including straight after reset) even though the
    // storage itself is not cleared; out_valid depends only on count, so
    // there is still no path from the inputs to these outputs.
    assign out_ctl     = out_valid ? ctl_mem[head]   : '0;
    assign out_illegal = out_valid ? ill_mem[head]   : 1'b0;
    assign out_instr   = out_valid ? instr_mem[head] : '0;
    assign out_pc      = out_valid ? pc_mem[head]    : '0;

endmodule
